// File: rtl/seq_det_pkg.sv
// Shared types and constants for the sequence-detector scheduler.
package seq_det_pkg;

    localparam int NUM_REQ = 2;

    localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
    localparam logic [2:0] ST_CLR_ENC   = 3'd1;
    localparam logic [2:0] ST_SHIFT_ENC = 3'd2;
    localparam logic [2:0] ST_DRAIN_ENC = 3'd3;
    localparam logic [2:0] ST_RESP_ENC  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE_ENC,
        CLR   = ST_CLR_ENC,
        SHIFT = ST_SHIFT_ENC,
        DRAIN = ST_DRAIN_ENC,
        RESP  = ST_RESP_ENC
    } sched_state_t;

endpackage

// File: rtl/seq_rr_arb2.sv
// Two-way round-robin arbiter: prefers rr_ptr, falls back to the other requester.
module seq_rr_arb2
    import seq_det_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_id
);

    always_comb begin
        grant_id = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
        grant    = '0;
        if (|req_valid) begin
            grant = grant_id ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/seq_det_scheduler.sv
// Time-multiplexes one serial Moore detector between two word requesters.
// Optional resp_first output enabled by defining SEQ_SCHED_FIRST_IDX_EN.
module seq_det_scheduler
    import seq_det_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REQ-1:0]  req_valid,
    input  logic [WORD_W-1:0]   req_word0,
    input  logic [WORD_W-1:0]   req_word1,
    output logic [NUM_REQ-1:0]  req_ready,
    output logic                det_rst_n,
    output logic                det_x,
    input  logic                det_z,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_id,
    output logic [CNT_W-1:0]    resp_count,
    output logic                busy
`ifdef SEQ_SCHED_FIRST_IDX_EN
    , output logic [CNT_W-1:0]  resp_first
`endif
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    sched_state_t       state, state_nxt;
    logic               rr_ptr;
    logic [WORD_W-1:0]  shift_reg;
    logic               id_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   bit_cnt;
    logic [NUM_REQ-1:0] grant;
    logic               grant_id;
    logic               sample_en;

    seq_rr_arb2 u_arb (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_id  (grant_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        det_x     = 1'b0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    req_ready = grant;
                    state_nxt = CLR;
                end
            end
            CLR:   state_nxt = SHIFT;
            SHIFT: begin
                det_x = shift_reg[0];
                if (bit_cnt == LAST_BIT) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: state_nxt = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // z1 lags det_x by one cycle: sample from the second SHIFT cycle through DRAIN
    assign sample_en = ((state == SHIFT) && (bit_cnt != '0)) || (state == DRAIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= 1'b0;
            shift_reg <= '0;
            id_reg    <= 1'b0;
            count_reg <= '0;
            bit_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        shift_reg <= grant_id ? req_word1 : req_word0;
                        id_reg    <= grant_id;
                        count_reg <= '0;
                        bit_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_reg >> 1;
                    bit_cnt   <= bit_cnt + CNT_W'(1);
                end
                RESP: begin
                    if (resp_ready) begin
                        rr_ptr <= ~id_reg;
                    end
                end
                default: ;
            endcase
            if (sample_en && det_z) begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

`ifdef SEQ_SCHED_FIRST_IDX_EN
    logic [CNT_W-1:0] first_reg;
    logic [CNT_W-1:0] sample_idx;

    assign sample_idx = (state == DRAIN) ? LAST_BIT : (bit_cnt - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_reg <= '1;
        end else if ((state == IDLE) && (|req_valid)) begin
            first_reg <= '1;
        end else if (sample_en && det_z && (first_reg == '1)) begin
            first_reg <= sample_idx;
        end
    end

    assign resp_first = first_reg;
`endif

    assign det_rst_n  = rst_n & (state != CLR);
    assign resp_valid = (state == RESP);
    assign resp_id    = id_reg;
    assign resp_count = count_reg;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Randomised self-checking bench for seq_det_scheduler with a "1101" overlapping Moore detector.
module tb_seq_det_scheduler;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    req_valid = '0;
    logic [W-1:0]  req_word0 = '0;
    logic [W-1:0]  req_word1 = '0;
    logic [1:0]    req_ready;
    logic          det_rst_n;
    logic          det_x;
    logic          det_z;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic          resp_id;
    logic [CW-1:0] resp_count;
    logic          busy;
`ifdef SEQ_SCHED_FIRST_IDX_EN
    logic [CW-1:0] resp_first;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    logic rr_model = 1'b0;
    int   dstate = 0;

    seq_det_scheduler #(.WORD_W(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_word0  (req_word0),
        .req_word1  (req_word1),
        .req_ready  (req_ready),
        .det_rst_n  (det_rst_n),
        .det_x      (det_x),
        .det_z      (det_z),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_count (resp_count),
        .busy       (busy)
`ifdef SEQ_SCHED_FIRST_IDX_EN
        , .resp_first (resp_first)
`endif
    );

    always #5 clk = ~clk;

    // Overlapping "1101" Moore detector, states count matched prefix length
    always @(posedge clk) begin
        if (!det_rst_n) dstate <= 0;
        else begin
            case (dstate)
                0: dstate <= det_x ? 1 : 0;
                1: dstate <= det_x ? 2 : 0;
                2: dstate <= det_x ? 2 : 3;
                3: dstate <= det_x ? 4 : 0;
                default: dstate <= det_x ? 2 : 0;
            endcase
        end
    end
    assign det_z = (dstate == 4);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ref_count(input logic [W-1:0] w);
        int n = 0;
        logic [W-1:0] sh;
        for (int i = 3; i < W; i++) begin
            sh = w >> (i - 3);
            if (sh[3:0] == 4'b1011) n++;
        end
        return n;
    endfunction

    function automatic int ref_first(input logic [W-1:0] w);
        logic [W-1:0] sh;
        for (int i = 3; i < W; i++) begin
            sh = w >> (i - 3);
            if (sh[3:0] == 4'b1011) return i;
        end
        return (1 << CW) - 1;
    endfunction

    task automatic run_round(input logic [1:0] mask, input logic [W-1:0] w0,
                             input logic [W-1:0] w1, input int stall);
        int t;
        int k;
        logic g;
        logic [W-1:0] w;
        int exp_cnt;
`ifdef SEQ_SCHED_FIRST_IDX_EN
        int exp_first;
`endif
        req_valid = mask;
        req_word0 = w0;
        req_word1 = w1;
        #1;
        t = 0;
        while (req_ready == 2'b00 && t < 20) begin
            @(negedge clk); #1;
            t++;
        end
        check("accept_wait", t, 0);
        g = mask[rr_model] ? rr_model : ~rr_model;
        check("grant", req_ready, g ? 2'b10 : 2'b01);
        w = g ? w1 : w0;
        exp_cnt = ref_count(w);
`ifdef SEQ_SCHED_FIRST_IDX_EN
        exp_first = ref_first(w);
`endif
        @(negedge clk); #1;
        req_valid = '0;
        k = 1;
        check("clr_det_rst_n", det_rst_n, 0);
        while (!resp_valid && k < 40) begin
            if (k >= 2 && k <= W + 1) check("det_x", det_x, w[k-2]);
            @(negedge clk); #1;
            k++;
        end
        check("latency", k, W + 3);
        check("resp_id", resp_id, g);
        check("resp_count", resp_count, exp_cnt);
`ifdef SEQ_SCHED_FIRST_IDX_EN
        check("resp_first", resp_first, exp_first);
`endif
        for (int s = 0; s < stall; s++) begin
            req_valid  = 2'b11;
            resp_ready = 1'b0;
            @(negedge clk); #1;
            check("stall_valid", resp_valid, 1);
            check("stall_id", resp_id, g);
            check("stall_count", resp_count, exp_cnt);
            check("stall_req_ready", req_ready, 0);
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        @(negedge clk); #1;
        resp_ready = 1'b0;
        check("post_busy", busy, 0);
        check("post_resp_valid", resp_valid, 0);
        rr_model = ~g;
    endtask

    task automatic abort_test();
        int t;
        int seen;
        req_valid = 2'b10;
        req_word1 = 8'h0B;
        #1;
        t = 0;
        while (req_ready == 2'b00 && t < 20) begin
            @(negedge clk); #1;
            t++;
        end
        check("abort_accept", req_ready, 2'b10);
        repeat (4) begin
            @(negedge clk); #1;
        end
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_det_rst_n", det_rst_n, 0);
        check("rst_req_ready", req_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rr_model = 1'b0;
        #1;
        seen = 0;
        repeat (15) begin
            @(negedge clk); #1;
            if (resp_valid) seen++;
        end
        check("abort_no_resp", seen, 0);
        check("abort_idle", busy, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("reset_req_ready", req_ready, 0);
        check("reset_det_x", det_x, 0);
        check("reset_resp_valid", resp_valid, 0);
        check("reset_resp_id", resp_id, 0);
        check("reset_resp_count", resp_count, 0);
        check("reset_busy", busy, 0);
        check("reset_det_rst_n", det_rst_n, 0);
`ifdef SEQ_SCHED_FIRST_IDX_EN
        check("reset_resp_first", resp_first, 4'hF);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        run_round(2'b01, 8'h0B, 8'h00, 0);
        run_round(2'b10, 8'h00, 8'h5B, 0);
        run_round(2'b01, 8'hFF, 8'h00, 0);
        run_round(2'b10, 8'h00, 8'h00, 0);
        repeat (4) run_round(2'b11, W'($urandom), W'($urandom), 0);
        run_round(2'b10, 8'h5B, 8'h0B, 0);
        run_round(2'b01, 8'h5B, 8'h00, 5);

        abort_test();

        for (int r = 0; r < 40; r++) begin
            run_round(2'($urandom_range(1, 3)), W'($urandom), W'($urandom),
                      int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
